control_unit_fsm: RTL

//  Multicycle control unit sequencing FULL_DATAPATH: fetches 16-bit instructions through the memory bank PC port, decodes them,
//  and drives every mb_*/dp_* control strobe (register-file reads/writes, ALU select, writeback mux, data-memory access).

---
 rtl/control_unit_fsm.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/control_unit_fsm.sv
// Multicycle control unit: fetches, decodes and sequences FULL_DATAPATH strobes.
// Optional build macro CU_SINGLE_STEP_EN adds a step input that gates each fetch.
module control_unit_fsm #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
  input  logic              CLK100MHZ,
  input  logic              RST,
  input  logic              start,
  input  logic [15:0]       mb_data_out,
  input  logic              dp_zf_flag,
`ifdef CU_SINGLE_STEP_EN
  input  logic              step,
`endif
  output logic              mb_sel,
  output logic [ADDR_W-1:0] mb_pc_addr,
  output logic [ADDR_W-1:0] mb_cu_addr,
  output logic              mb_mem_read,
  output logic              mb_mem_write,
  output logic [7:0]        dp_imm,
  output logic [1:0]        dp_sel,
  output logic [3:0]        dp_write_addr,
  output logic              dp_write,
  output logic [3:0]        dp_a_addr,
  output logic              dp_a_read,
  output logic [3:0]        dp_b_addr,
  output logic              dp_b_read,
  output logic [3:0]        dp_alu_sel,
  output logic [ADDR_W-1:0] pc,
  output logic [15:0]       ir,
  output logic              halted
);

  typedef enum logic [2:0] {IDLE, FETCH, FETCH_WAIT, DECODE, EXEC, MEM_WAIT, HALT} state_t;

  localparam logic [3:0] OP_ALU_MAX = 4'h8;
  localparam logic [3:0] OP_LDI     = 4'h9;
  localparam logic [3:0] OP_LD      = 4'hA;
  localparam logic [3:0] OP_ST      = 4'hB;
  localparam logic [3:0] OP_JMP     = 4'hC;
  localparam logic [3:0] OP_JZ      = 4'hD;
  localparam logic [3:0] OP_HALT    = 4'hF;

  state_t            state, state_n;
  logic [ADDR_W-1:0] pc_n;
  logic [15:0]       ir_n;
  logic              fetch_go;

  logic [3:0]        op;
  logic [ADDR_W-1:0] imm_a;
  assign op    = ir[15:12];
  assign imm_a = ADDR_W'(ir[7:0]);

  assign mb_pc_addr = pc;

`ifdef CU_SINGLE_STEP_EN
  assign fetch_go = step;
`else
  assign fetch_go = 1'b1;
`endif

  // A FETCH cycle only advances once its read strobe has actually been issued.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    ir_n    = ir;
    unique case (state)
      IDLE:       if (start) state_n = FETCH;
      FETCH:      if (mb_mem_read) state_n = FETCH_WAIT;
      FETCH_WAIT: begin
        ir_n    = mb_data_out;
        pc_n    = pc + ADDR_W'(1);
        state_n = DECODE;
      end
      DECODE:     state_n = EXEC;
      EXEC: begin
        state_n = FETCH;
        case (op)
          OP_LD:   state_n = MEM_WAIT;
          OP_JMP:  pc_n = imm_a;
          OP_JZ:   if (dp_zf_flag) pc_n = imm_a;
          OP_HALT: state_n = HALT;
          default: ;
        endcase
      end
      MEM_WAIT:   state_n = FETCH;
      HALT:       state_n = HALT;
      default:    state_n = IDLE;
    endcase
  end

  logic [3:0]        n_op, n_rd, n_ra, n_rb;
  logic [ADDR_W-1:0] n_imm;
  assign n_op  = ir_n[15:12];
  assign n_rd  = ir_n[11:8];
  assign n_ra  = ir_n[7:4];
  assign n_rb  = ir_n[3:0];
  assign n_imm = ADDR_W'(ir_n[7:0]);

  logic              nx_sel, nx_mem_read, nx_mem_write, nx_write, nx_a_read, nx_b_read, nx_halted;
  logic [ADDR_W-1:0] nx_cu_addr;
  logic [7:0]        nx_imm;
  logic [1:0]        nx_dp_sel;
  logic [3:0]        nx_write_addr, nx_a_addr, nx_b_addr, nx_alu_sel;

  // Outputs are decoded from the upcoming state so they can be registered.
  always_comb begin
    nx_sel        = 1'b0;
    nx_mem_read   = 1'b0;
    nx_mem_write  = 1'b0;
    nx_cu_addr    = '0;
    nx_imm        = '0;
    nx_dp_sel     = 2'b00;
    nx_write_addr = '0;
    nx_write      = 1'b0;
    nx_a_addr     = '0;
    nx_a_read     = 1'b0;
    nx_b_addr     = '0;
    nx_b_read     = 1'b0;
    nx_alu_sel    = '0;
    nx_halted     = 1'b0;
    case (state_n)
      FETCH:  nx_mem_read = fetch_go;
      DECODE: begin
        nx_a_read = 1'b1;
        nx_a_addr = (n_op == OP_ST) ? n_rd : n_ra;
        nx_b_read = 1'b1;
        nx_b_addr = n_rb;
      end
      EXEC: begin
        if (n_op <= OP_ALU_MAX) begin
          nx_write      = 1'b1;
          nx_write_addr = n_rd;
          nx_alu_sel    = n_op;
          nx_a_read     = 1'b1;
          nx_a_addr     = n_ra;
          nx_b_read     = 1'b1;
          nx_b_addr     = n_rb;
        end else if (n_op == OP_LDI) begin
          nx_dp_sel     = 2'b10;
          nx_imm        = ir_n[7:0];
          nx_write      = 1'b1;
          nx_write_addr = n_rd;
        end else if (n_op == OP_LD) begin
          nx_sel      = 1'b1;
          nx_cu_addr  = n_imm;
          nx_mem_read = 1'b1;
        end else if (n_op == OP_ST) begin
          nx_sel       = 1'b1;
          nx_cu_addr   = n_imm;
          nx_mem_write = 1'b1;
          nx_a_read    = 1'b1;
          nx_a_addr    = n_rd;
        end
      end
      MEM_WAIT: begin
        nx_sel        = 1'b1;
        nx_mem_read   = 1'b1;
        nx_cu_addr    = n_imm;
        nx_dp_sel     = 2'b01;
        nx_write      = 1'b1;
        nx_write_addr = n_rd;
      end
      HALT:    nx_halted = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK100MHZ) begin
    if (RST) begin
      state         <= IDLE;
      pc            <= PC_RESET;
      ir            <= '0;
      mb_sel        <= 1'b0;
      mb_mem_read   <= 1'b0;
      mb_mem_write  <= 1'b0;
      mb_cu_addr    <= '0;
      dp_imm        <= '0;
      dp_sel        <= 2'b00;
      dp_write_addr <= '0;
      dp_write      <= 1'b0;
      dp_a_addr     <= '0;
      dp_a_read     <= 1'b0;
      dp_b_addr     <= '0;
      dp_b_read     <= 1'b0;
      dp_alu_sel    <= '0;
      halted        <= 1'b0;
    end else begin
      state         <= state_n;
      pc            <= pc_n;
      ir            <= ir_n;
      mb_sel        <= nx_sel;
      mb_mem_read   <= nx_mem_read;
      mb_mem_write  <= nx_mem_write;
      mb_cu_addr    <= nx_cu_addr;
      dp_imm        <= nx_imm;
      dp_sel        <= nx_dp_sel;
      dp_write_addr <= nx_write_addr;
      dp_write      <= nx_write;
      dp_a_addr     <= nx_a_addr;
      dp_a_read     <= nx_a_read;
      dp_b_addr     <= nx_b_addr;
      dp_b_read     <= nx_b_read;
      dp_alu_sel    <= nx_alu_sel;
      halted        <= nx_halted;
    end
  end

endmodule
